// File: rtl/eth_pkg.sv
// Shared RMII MAC definitions: dibit codes, CRC-32 constants, frame limits, rx state encoding.
// The byte-wide CRC step feeds data LSB-first into an MSB-first register, matching the transmitter.
package eth_pkg;

  localparam logic [1:0]  PREAMBLE_0x5   = 2'b01;
  localparam logic [1:0]  SFD_0xD        = 2'b11;
  localparam logic [31:0] CRC_RESIDUE    = 32'hC704_DD7B;
  localparam logic [31:0] CRC_POLY       = 32'h04C1_1DB7;
  localparam logic [31:0] CRC_INIT       = 32'hFFFF_FFFF;
  localparam logic [10:0] FRAME_MAX_SIZE = 11'd1518;
  localparam logic [10:0] RUNT_SIZE      = 11'd64;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_PRE,
    RX_DATA,
    RX_SKIP,
    RX_HOLD
  } rx_state_t;

  function automatic logic [31:0] crc32_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    logic        fb;
    r = c;
    for (int i = 0; i < 8; i++) begin
      fb = r[31] ^ d[i];
      r  = {r[30:0], 1'b0} ^ (fb ? CRC_POLY : 32'd0);
    end
    return r;
  endfunction

endpackage

// File: rtl/eth_rx_if.sv
// RMII receive, RAM write and result handshake bundle; master is the receiver, slave the PHY/consumer side.
// The result is held by the receiver until the consumer acknowledges it.
interface eth_rx_if;
  logic [1:0]  i_eth_data;
  logic        i_eth_crs_dv;
  logic [7:0]  o_ram_data;
  logic [10:0] o_ram_adr;
  logic        o_ram_we;
  logic        o_rx_valid;
  logic        i_rx_ack;
  logic [10:0] o_rx_size;
  logic        o_crc_ok;
  logic        o_err_align;
  logic        o_err_len;
  logic        o_drop;

  modport master (
    input  i_eth_data, i_eth_crs_dv, i_rx_ack,
    output o_ram_data, o_ram_adr, o_ram_we, o_rx_valid, o_rx_size,
           o_crc_ok, o_err_align, o_err_len, o_drop
  );

  modport slave (
    output i_eth_data, i_eth_crs_dv, i_rx_ack,
    input  o_ram_data, o_ram_adr, o_ram_we, o_rx_valid, o_rx_size,
           o_crc_ok, o_err_align, o_err_len, o_drop
  );
endinterface

// File: rtl/crc.sv
// Byte-wide CRC-32 register shared with the transmitter; one byte per enabled cycle.
// Result visible the cycle after i_en; i_init takes priority over i_en.
module crc
  import eth_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_init,
  input  logic        i_en,
  input  logic [7:0]  i_data,
  output logic [31:0] o_crc
);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)       o_crc <= CRC_INIT;
    else if (i_init) o_crc <= CRC_INIT;
    else if (i_en)   o_crc <= crc32_byte(o_crc, i_data);
  end

endmodule

// File: rtl/eth_rx.sv
// RMII receiver: strips preamble/SFD, writes bytes to RAM from address 0, checks CRC-32 and reports the result.
// Writes land 1 cycle after each 4th dibit, result 2 cycles after CRS_DV drops; frames arriving while a result is unacknowledged are dropped.
module eth_rx
  import eth_pkg::*;
(
  input  logic     i_clk,
  input  logic     i_rst,
  eth_rx_if.master bus
);

  rx_state_t   state;
  logic        armed, ending, trunc, misalign, dropping, crc_init;
  logic [1:0]  dcnt;
  logic [5:0]  byte_sh;
  logic [10:0] adr;
  logic [31:0] crc_val;

  logic [1:0]  dibit;
  logic        dv, ack, pre_start, res_crc_ok, res_len;

  assign dibit      = bus.i_eth_data;
  assign dv         = bus.i_eth_crs_dv;
  assign ack        = bus.i_rx_ack;
  assign pre_start  = dv && (dibit == PREAMBLE_0x5);
  assign res_crc_ok = (crc_val == CRC_RESIDUE);
  assign res_len    = trunc || (adr < RUNT_SIZE);

  // The RAM write strobe doubles as the CRC feed, so the CRC lags the write by one cycle.
  crc u_crc (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_init (crc_init),
    .i_en   (bus.o_ram_we),
    .i_data (bus.o_ram_data),
    .o_crc  (crc_val)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state           <= RX_IDLE;
      armed           <= 1'b0;
      ending          <= 1'b0;
      trunc           <= 1'b0;
      misalign        <= 1'b0;
      dropping        <= 1'b0;
      crc_init        <= 1'b0;
      dcnt            <= 2'd0;
      byte_sh         <= 6'd0;
      adr             <= 11'd0;
      bus.o_ram_data  <= 8'd0;
      bus.o_ram_adr   <= 11'd0;
      bus.o_ram_we    <= 1'b0;
      bus.o_rx_valid  <= 1'b0;
      bus.o_rx_size   <= 11'd0;
      bus.o_crc_ok    <= 1'b0;
      bus.o_err_align <= 1'b0;
      bus.o_err_len   <= 1'b0;
      bus.o_drop      <= 1'b0;
    end else begin
      bus.o_ram_we <= 1'b0;
      bus.o_drop   <= 1'b0;
      crc_init     <= 1'b0;
      if (!dv) armed <= 1'b1;

      case (state)
        RX_IDLE: if (armed && pre_start) state <= RX_PRE;

        RX_PRE: begin
          if (!dv) begin
            state <= RX_IDLE;
          end else if (dibit == SFD_0xD) begin
            state    <= RX_DATA;
            crc_init <= 1'b1;
            adr      <= 11'd0;
            dcnt     <= 2'd0;
            ending   <= 1'b0;
            trunc    <= 1'b0;
            misalign <= 1'b0;
          end else if (dibit != PREAMBLE_0x5) begin
            state <= RX_SKIP;
            trunc <= 1'b0;
          end
        end

        RX_DATA: begin
          if (ending) begin
            state           <= RX_HOLD;
            bus.o_rx_valid  <= 1'b1;
            bus.o_rx_size   <= adr;
            bus.o_crc_ok    <= res_crc_ok;
            bus.o_err_align <= misalign;
            bus.o_err_len   <= res_len;
          end else if (!dv) begin
            ending   <= 1'b1;
            misalign <= (dcnt != 2'd0);
          end else if (adr == FRAME_MAX_SIZE) begin
            trunc <= 1'b1;
            state <= RX_SKIP;
          end else begin
            dcnt <= dcnt + 2'd1;
            case (dcnt)
              2'd0: byte_sh[1:0] <= dibit;
              2'd1: byte_sh[3:2] <= dibit;
              2'd2: byte_sh[5:4] <= dibit;
              default: begin
                bus.o_ram_we   <= 1'b1;
                bus.o_ram_data <= {dibit, byte_sh};
                bus.o_ram_adr  <= adr;
                adr            <= adr + 11'd1;
              end
            endcase
          end
        end

        RX_SKIP: begin
          if (!dv) begin
            if (trunc) begin
              state           <= RX_HOLD;
              bus.o_rx_valid  <= 1'b1;
              bus.o_rx_size   <= adr;
              bus.o_crc_ok    <= res_crc_ok;
              bus.o_err_align <= misalign;
              bus.o_err_len   <= res_len;
            end else begin
              state <= RX_IDLE;
            end
          end
        end

        RX_HOLD: begin
          if (ack) begin
            bus.o_rx_valid <= 1'b0;
            dropping       <= 1'b0;
            trunc          <= 1'b0;
            // A frame already being dropped must not be picked up halfway through.
            if (dropping && dv)                     state <= RX_SKIP;
            else if (armed && pre_start && !dropping) state <= RX_PRE;
            else                                    state <= RX_IDLE;
          end else if (!dv) begin
            dropping <= 1'b0;
          end else if (pre_start && !dropping) begin
            dropping   <= 1'b1;
            bus.o_drop <= 1'b1;
          end
        end

        default: state <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_eth_rx.sv
// Directed bench for eth_rx: table of frames plus hand sequences for drop, ack-at-start and reset mid-frame.
module tb_eth_rx;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #10 clk = ~clk;

  eth_rx_if bus ();

  eth_rx dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  typedef struct {
    string name;
    int    npay;
    int    flip;
    int    extra;
    int    nsend;
    int    exp_wr;
    int    exp_size;
    bit    chk_crc;
    bit    exp_crc;
    bit    exp_align;
    bit    exp_len;
    bit    trunc;
  } vec_t;

  vec_t       tbl [7];
  logic [7:0] frm [0:2047];
  int         flen = 0;
  int         total = 0;
  int         bad = 0;
  int         wr_cnt = 0;
  int         wr_bad = 0;
  int         last_adr = -1;
  int         drop_cnt = 0;
  logic       valid_before_end = 1'b0;

  always @(posedge clk) begin
    #1;
    if (bus.o_ram_we) begin
      wr_cnt++;
      last_adr = int'(bus.o_ram_adr);
      if (int'(bus.o_ram_adr) >= flen || bus.o_ram_data !== frm[bus.o_ram_adr]) wr_bad++;
    end
    if (bus.o_drop) drop_cnt++;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Reflected (LSB-first) reference CRC; FCS goes out least significant byte first.
  function automatic logic [31:0] fcs_of(input int n);
    logic [31:0] c;
    c = 32'hFFFF_FFFF;
    for (int i = 0; i < n; i++) begin
      c = c ^ {24'd0, frm[i]};
      for (int j = 0; j < 8; j++)
        c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
    end
    return ~c;
  endfunction

  task automatic build_frame(input int npay, input int seed, input int flip);
    logic [31:0] f;
    for (int i = 0; i < npay; i++) frm[i] = 8'((i * 37 + seed) & 255);
    f = fcs_of(npay);
    for (int k = 0; k < 4; k++) frm[npay + k] = f[8*k +: 8];
    flen = npay + 4;
    if (flip >= 0) frm[flip] = frm[flip] ^ 8'h01;
  endtask

  task automatic dib(input logic dv, input logic [1:0] d, input logic ack, input logic r);
    @(negedge clk);
    bus.i_eth_crs_dv = dv;
    bus.i_eth_data   = d;
    bus.i_rx_ack     = ack;
    rst              = r;
  endtask

  task automatic send_frame(input int nbytes, input int extra, input int rst_at, input bit ack_first);
    logic [7:0] b;
    dib(1'b0, 2'b00, 1'b0, 1'b0);
    dib(1'b0, 2'b00, 1'b0, 1'b0);
    for (int p = 0; p < 32; p++)
      dib(1'b1, (p == 31) ? 2'b11 : 2'b01, ack_first && (p == 0), 1'b0);
    for (int i = 0; i < nbytes; i++) begin
      b = frm[i];
      for (int j = 0; j < 4; j++)
        dib(1'b1, b[2*j +: 2], 1'b0, (i == rst_at) && (j == 0));
    end
    for (int e = 0; e < extra; e++) dib(1'b1, 2'b10, 1'b0, 1'b0);
    valid_before_end = bus.o_rx_valid;
    dib(1'b0, 2'b00, 1'b0, 1'b0);
  endtask

  task automatic do_ack(input string nm);
    dib(1'b0, 2'b00, 1'b1, 1'b0);
    @(posedge clk); #1;
    chk({nm, "_ack"}, bus.o_rx_valid, 1'b0);
    dib(1'b0, 2'b00, 1'b0, 1'b0);
  endtask

  task automatic run_frame(input vec_t v, input int seed, input bit ack_it, input bit ack_first);
    int n;
    build_frame(v.npay, seed, v.flip);
    wr_cnt = 0; wr_bad = 0; last_adr = -1;
    send_frame(v.nsend, v.extra, -1, ack_first);
    chk({v.name, "_early_valid"}, valid_before_end, 1'b0);
    if (v.trunc) begin
      n = 0;
      while (!bus.o_rx_valid && n < 8) begin
        @(posedge clk); #1;
        n++;
      end
      chk({v.name, "_valid"}, bus.o_rx_valid, 1'b1);
    end else begin
      @(posedge clk); #1;
      chk({v.name, "_lat1"}, bus.o_rx_valid, 1'b0);
      @(posedge clk); #1;
      chk({v.name, "_lat2"}, bus.o_rx_valid, 1'b1);
    end
    chk({v.name, "_writes"}, wr_cnt, v.exp_wr);
    chk({v.name, "_wdata"}, wr_bad, 0);
    chk({v.name, "_last_adr"}, last_adr, v.exp_wr - 1);
    chk({v.name, "_size"}, bus.o_rx_size, v.exp_size);
    chk({v.name, "_align"}, bus.o_err_align, v.exp_align);
    chk({v.name, "_len"}, bus.o_err_len, v.exp_len);
    if (v.chk_crc) chk({v.name, "_crc"}, bus.o_crc_ok, v.exp_crc);
    if (ack_it) do_ack(v.name);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: time limit reached, valid=%0d", bus.o_rx_valid);
    $fatal(1);
  end

  initial begin
    vec_t v3;
    int   dc0;

    //           name        npay  flip ext nsend  wr    size  chk crc al len tr
    tbl[0] = '{"good",       60,   -1,  0,  64,    64,   64,   1,  1,  0, 0,  0};
    tbl[1] = '{"corrupt",    60,   10,  0,  64,    64,   64,   1,  0,  0, 0,  0};
    tbl[2] = '{"misalign",   60,   -1,  2,  64,    64,   64,   1,  1,  1, 0,  0};
    tbl[3] = '{"runt63",     59,   -1,  0,  63,    63,   63,   1,  1,  0, 1,  0};
    tbl[4] = '{"runt44",     40,   -1,  0,  44,    44,   44,   1,  1,  0, 1,  0};
    tbl[5] = '{"max1518",    1514, -1,  0,  1518,  1518, 1518, 1,  1,  0, 0,  0};
    tbl[6] = '{"over1520",   1516, -1,  0,  1520,  1518, 1518, 0,  0,  0, 1,  1};

    bus.i_eth_crs_dv = 1'b0;
    bus.i_eth_data   = 2'b00;
    bus.i_rx_ack     = 1'b0;
    rst              = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ram", {bus.o_ram_data, bus.o_ram_adr, bus.o_ram_we}, 0);
    chk("rst_res", {bus.o_rx_valid, bus.o_rx_size, bus.o_crc_ok, bus.o_err_align,
                    bus.o_err_len, bus.o_drop}, 0);
    dib(1'b0, 2'b00, 1'b0, 1'b0);

    for (int i = 0; i < 7; i++) run_frame(tbl[i], i * 13 + 1, 1'b1, 1'b0);

    // Result held: the next frame must be dropped without touching RAM or the result.
    run_frame(tbl[0], 11, 1'b0, 1'b0);
    build_frame(46, 23, -1);
    wr_cnt = 0; wr_bad = 0; dc0 = drop_cnt;
    send_frame(50, 0, -1, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk("noack_drop", drop_cnt - dc0, 1);
    chk("noack_writes", wr_cnt, 0);
    chk("noack_valid", bus.o_rx_valid, 1'b1);
    chk("noack_size", bus.o_rx_size, 64);
    chk("noack_crc", bus.o_crc_ok, 1'b1);
    do_ack("noack");

    v3 = tbl[0];
    v3.name = "third"; v3.npay = 66; v3.nsend = 70; v3.exp_wr = 70; v3.exp_size = 70;
    run_frame(v3, 31, 1'b0, 1'b0);

    // Ack in the same cycle as the first preamble dibit accepts the new frame.
    dc0 = drop_cnt;
    v3 = tbl[0];
    v3.name = "ackstart";
    run_frame(v3, 41, 1'b1, 1'b1);
    chk("ackstart_nodrop", drop_cnt - dc0, 0);

    // Reset at byte 20; remainder carries preamble/SFD-like bytes that must be ignored.
    build_frame(60, 91, -1);
    for (int i = 21; i < 41; i++) frm[i] = (i % 2 == 1) ? 8'h55 : 8'hD5;
    wr_cnt = 0; wr_bad = 0; last_adr = -1; dc0 = drop_cnt;
    send_frame(64, 0, 20, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    chk("rst_mid_writes", wr_cnt, 20);
    chk("rst_mid_last_adr", last_adr, 19);
    chk("rst_mid_wdata", wr_bad, 0);
    chk("rst_mid_valid", bus.o_rx_valid, 1'b0);
    chk("rst_mid_size", bus.o_rx_size, 0);
    chk("rst_mid_drop", drop_cnt - dc0, 0);

    v3 = tbl[0];
    v3.name = "after_rst";
    run_frame(v3, 53, 1'b1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/eth_rx.md
# eth_rx

RMII receive path: samples 2-bit dibits from the PHY on the 50 MHz MAC clock, strips preamble/SFD, and writes each received byte to an external 8-bit RAM from address 0. It computes CRC-32 over the frame including FCS, then reports byte count and status to the packet-processing logic through a valid/ack handshake. It mirrors the transmitter and shares its RAM interface style and CRC unit.

## Interface
- FRAME_MAX_SIZE, 11'd1518, maximum stored bytes including the 4-byte FCS.
- RUNT_SIZE, 11'd64, minimum legal frame length including FCS.

- i_clk  in  1  MAC clock, one dibit per cycle.
- i_rst  in  1  asynchronous, active-high reset.
- i_eth_data  in  2  RMII RXD[1:0].
- i_eth_crs_dv  in  1  RMII CRS_DV, used directly as the frame envelope.
- o_ram_data  out  8  byte to store.
- o_ram_adr  out  11  byte address.
- o_ram_we  out  1  one-cycle write strobe.
- o_rx_valid  out  1  frame result available; held until ack.
- i_rx_ack  in  1  consumer releases the result and the RAM.
- o_rx_size  out  11  stored byte count, FCS included.
- o_crc_ok  out  1  CRC residue matched.
- o_err_align  out  1  frame ended mid-byte.
- o_err_len  out  1  frame is longer than FRAME_MAX_SIZE or shorter than RUNT_SIZE.
- o_drop  out  1  one-cycle pulse when a frame is ignored because the result is still unacknowledged.

## Operation
- States: IDLE, PRE, DATA, SKIP, HOLD.
- **IDLE**
  - Requires `armed`, which is set after crs_dv has been sampled low at least once since reset.
  - crs_dv=1 with dibit 01 moves to PRE.
  - Any other dibit leaves the state in IDLE.
- **PRE**
  - Dibit 01 stays in PRE.
  - Dibit 11 (SFD) moves to DATA. In the same cycle, reset the CRC, byte address and dibit counter.
  - Dibit 00 or 10 moves to SKIP.
  - crs_dv=0 returns to IDLE.
- **DATA**
  - Dibits are assembled LSB-first: dibit k lands in byte bits [2k+1:2k].
  - When the 4th dibit arrives, write the byte at the current address, feed the CRC, then increment the address.
  - crs_dv=0 ends the frame and moves to HOLD after the CRC settles.
  - If the byte count reaches FRAME_MAX_SIZE and more data arrives: set err_len, stop writing and move to SKIP.
- **SKIP**
  - Waits for crs_dv=0, then moves to HOLD when the frame was truncated, otherwise to IDLE.
- **HOLD**
  - o_rx_valid=1, with size and status frozen.
  - i_rx_ack=1 clears valid and returns to IDLE.
  - Only a frame whose 01 preamble begins while valid is held and no ack is present is ignored: pulse o_drop once, perform no RAM writes, and skip the frame until crs_dv=0.
- **CRC**
  - Uses the existing byte-wide CRC-32 unit: polynomial 0x04C11DB7, init 0xFFFFFFFF, data bit-reversed on input exactly as on transmit.
  - crc_ok=1 iff the register equals residue 0xC704DD7B after the last byte, including the FCS.
- **Status**
  - err_align=1 if crs_dv drops with the dibit counter ≠ 0; the partial byte is discarded and not written.
  - err_len=1 if size < RUNT_SIZE or a truncation occurred.

## Timing
- Reset values: every output 0, state IDLE, armed=0, CRC at init.
- Write latency: o_ram_we, o_ram_data and o_ram_adr are registered and valid together on the cycle after the 4th dibit of each byte is sampled.
- Result latency: o_rx_valid rises exactly 2 cycles after the first crs_dv=0 sample in DATA.
- Ack timing: valid falls the cycle after i_rx_ack is sampled high.
- Ack with simultaneous frame start: if a 01 preamble arrives in the same cycle as ack, the frame is accepted.
- Ack while not valid: ignored.
- Reset mid-frame: abort immediately with no valid. The block then ignores the remainder of the frame until crs_dv has been low for one cycle.
- Address width: 11 bits, never wraps, because it is bounded by FRAME_MAX_SIZE.

## Structure
- Shared package eth_pkg holds:
  - the dibit constants PREAMBLE_0x5=2'b01 and SFD_0xD=2'b11;
  - CRC_RESIDUE=32'hC704DD7B;
  - the default frame limits;
  - the rx state enum.
- One sub-module: crc, the existing byte-wide CRC-32 unit shared with the transmitter.

## Test plan
- **Good frame:** 7×0x55, 0xD5, 60 payload bytes, valid FCS.
  - 64 writes at adr 0..63, bytes matching the stimulus.
  - valid=1, size=64, crc_ok=1, both errors 0.
- **Corrupted frame:** same frame with payload byte 10 bit 0 flipped.
  - 64 writes, crc_ok=0, size=64.
- **Misaligned end:** crs_dv drops 2 dibits into byte 65.
  - err_align=1, size=64, no write of the partial byte.
- **Oversize:** 1520-byte frame.
  - Exactly 1518 writes (last at adr 1517), err_len=1, valid only after crs_dv=0.
- **No ack:** good frame, ack withheld, second frame sent.
  - o_drop pulses once, no writes, first result unchanged.
  - Ack then a third frame is accepted normally.
- **Reset mid-frame:** i_rst pulsed at byte 20 while crs_dv stays high and the rest of the frame (including 01/11 patterns) continues.
  - No writes and no valid.
  - A following frame after a crs_dv low gap is received correctly.
